md_tx_pkt_buffer: RTL and testbench
===================================

Name: md_tx_pkt_buffer

Overview:
- Store-and-forward packet buffer between the FAST UM pipeline output and the MD AXIS wrapper TX input.
- The FAST pipeline writes beats with a write strobe and cannot stall mid-packet. This block absorbs packets, exposes an early-warning ready upstream, and presents clean valid/ready AXIS-style beats downstream.
- Only complete packets are released. Overflowing or malformed packets are rolled back and counted, never truncated.

Parameters:
- DEPTH, 64, buffer depth in 256-bit beats; power of two, at least 4.
- HEADROOM, 8, free beats still left when in_ready deasserts.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  256  beat data from UM
- in_data_wr  in  1  beat write strobe; one beat per cycle when high
- in_keep  in  32  byte enables
- in_user  in  2  bit0 = eop, bit1 = sop
- in_ready  out  1  upstream may start/continue packets (advisory)
- out_data  out  256  beat data to wrapper
- out_keep  out  32  byte enables
- out_user  out  2  same encoding as in_user
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- pkt_out_cnt  out  CNT_W  packets fully emitted (eop handshakes)
- pkt_drop_cnt  out  CNT_W  packets discarded
- level  out  $clog2(DEPTH)+1  written beats currently held, committed plus uncommitted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). All flops clear on reset assertion.
- Reset values:
  - out_valid=0, out_data/out_keep/out_user=0.
  - Counters=0, level=0, in_ready=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
  - Reset mid-packet discards all contents, including committed packets.
- Pointers: wr_ptr, commit_ptr, rd_ptr, each $clog2(DEPTH)+1 bits, wrap naturally.
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - level = wr_ptr - rd_ptr.
- in_ready is registered: 1 iff level <= DEPTH-HEADROOM.
- Write FSM states:
  - IDLE: waiting for sop.
  - PKT: receiving a packet.
  - DROP: discarding until eop.
- Write transitions:
  - IDLE, wr with sop:
    - Store the beat.
    - If eop is also set, commit at once and stay in IDLE; otherwise go to PKT.
  - IDLE, wr without sop: drop the beat, pkt_drop_cnt+1, go to DROP (or stay IDLE if eop is set).
  - PKT, wr with sop (missing eop):
    - Roll back the partial packet: wr_ptr := commit_ptr.
    - pkt_drop_cnt+1.
    - Store the new beat as a fresh packet.
  - PKT, wr with eop: store the beat, commit_ptr := wr_ptr+1, go to IDLE.
  - Any wr while full: roll back (wr_ptr := commit_ptr), drop the beat, pkt_drop_cnt+1.
    - Then go to DROP, or to IDLE if the beat carries eop.
  - DROP: discard beats. An eop beat returns to IDLE. A sop beat is accepted as a new packet, as in IDLE.
- Full is evaluated on the same cycle's read: a simultaneous read frees a slot before the write check.
- Read side:
  - Only beats below commit_ptr are readable.
  - First-word-fall-through output register. out_* hold stable while out_valid && !out_ready.
  - Beats advance one per cycle under continuous out_ready.
- Latency: eop beat sampled at edge k; the packet's first beat has out_valid=1 after edge k+2. Back-to-back committed packets flow without bubbles.
- pkt_out_cnt increments on out_valid && out_ready && out_user[0]. Counters wrap at 2^CNT_W.
- A packet longer than DEPTH beats always overflows and is dropped.

Decomposition:
- Shared package md_pkg:
  - USER_EOP=0, USER_SOP=1 bit indices.
  - DATA_W=256, KEEP_W=32.
  - Write FSM state typedef/localparams.
- Sub-module md_sdp_ram:
  - Simple dual-port RAM, DEPTH x (256+32+2), registered read, 1-cycle latency.
  - The buffer wraps it with the output prefetch register.

Test Plan:
- 4-beat packet (sop on beat0, eop on beat3), out_ready=1 -> out_valid rises 2 edges after eop sample; 4 beats in order with matching keep/user; pkt_out_cnt=1, level returns to 0.
- 10 back-to-back 1-beat packets (sop|eop), out_ready=1 -> 10 beats emitted contiguously with no bubbles; pkt_out_cnt=10, pkt_drop_cnt=0.
- out_ready=0, write 7 packets of 8 beats (DEPTH=64, HEADROOM=8) -> in_ready falls once level>56; 57th beat stored, 64 beats accepted; the 65th beat triggers rollback of packet 8, pkt_drop_cnt=1, level=56. Release out_ready -> exactly 7 packets out.
- Packet A: 3 beats without eop, then a new sop -> A rolled back, pkt_drop_cnt=1; the following packet emitted intact.
- Headless beats (no sop in IDLE): 3 beats ending with eop -> all dropped, pkt_drop_cnt=1, out_valid stays 0; next sop packet passes.
- Assert rst_n mid-emission of committed packets -> out_valid=0 immediately (async), level=0; after release in_ready=1 one edge later and a new packet passes normally.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the MD TX path: beat payload layout, user-bit indices
// and the packet buffer write FSM encoding.
package md_pkg;

  localparam int unsigned DATA_W   = 256;
  localparam int unsigned KEEP_W   = 32;
  localparam int unsigned USER_W   = 2;
  localparam int unsigned USER_EOP = 0;
  localparam int unsigned USER_SOP = 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [USER_W-1:0] user;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  typedef enum logic [1:0] {
    WS_IDLE = 2'd0,
    WS_PKT  = 2'd1,
    WS_DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/md_sdp_ram.sv
// Simple dual-port beat RAM: one write port, one registered read port.
// Read data holds its value while rd_en is low.
module md_sdp_ram
  import md_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = BEAT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-address read/write returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/md_tx_pkt_buffer.sv
// Store-and-forward packet buffer between the FAST UM pipeline and the MD AXIS
// TX wrapper. Only complete packets are released; bad packets are rolled back.
module md_tx_pkt_buffer
  import md_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned HEADROOM = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_data_wr,
  input  logic [KEEP_W-1:0]        in_keep,
  input  logic [USER_W-1:0]        in_user,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [KEEP_W-1:0]        out_keep,
  output logic [USER_W-1:0]        out_user,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         pkt_out_cnt,
  output logic [CNT_W-1:0]         pkt_drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  wr_state_e        state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] commit_ptr, commit_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0] fetch_ptr;
  logic [PTR_W-1:0] wbase;
  logic [PTR_W-1:0] level_nxt;
  logic             wr_sop, wr_eop, pkt_beat, full_c;
  logic             ram_we, drop_inc;
  logic [AW-1:0]    ram_waddr;
  logic             pop, avail, s1_valid, out_load, rd_issue;
  beat_t            wr_beat, rd_beat;
  logic [BEAT_W-1:0] rd_word;

  assign wr_sop   = in_data_wr && in_user[USER_SOP];
  assign wr_eop   = in_user[USER_EOP];
  // A beat that belongs to a packet: a fresh sop, or any beat while receiving.
  assign pkt_beat = in_data_wr && (in_user[USER_SOP] || (state == WS_PKT));

  // rd_ptr retires beats only when they leave the output register, so the
  // prefetched beats keep their RAM slots reserved.
  assign pop        = out_valid && out_ready;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
  assign full_c     = (wr_ptr - rd_ptr_nxt) == PTR_W'(DEPTH);
  assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  assign wr_beat = '{data: in_data, keep: in_keep, user: in_user};

  // Write FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WS_IDLE;
    else        state <= state_nxt;
  end

  // Write FSM next state
  always_comb begin
    state_nxt = state;
    if (in_data_wr) begin
      if (pkt_beat && !full_c) state_nxt = wr_eop ? WS_IDLE : WS_PKT;
      else                     state_nxt = wr_eop ? WS_IDLE : WS_DROP;
    end
  end

  // Write FSM actions: store, commit, roll back, count drops
  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    wbase          = wr_ptr;
    ram_we         = 1'b0;
    ram_waddr      = wr_ptr[AW-1:0];
    drop_inc       = 1'b0;
    if (in_data_wr) begin
      if (pkt_beat && !full_c) begin
        // A sop inside a packet restarts from the last commit point.
        if (state == WS_PKT && wr_sop) begin
          wbase    = commit_ptr;
          drop_inc = 1'b1;
        end
        ram_we     = 1'b1;
        ram_waddr  = wbase[AW-1:0];
        wr_ptr_nxt = wbase + PTR_W'(1);
        if (wr_eop) commit_ptr_nxt = wbase + PTR_W'(1);
      end else if (pkt_beat) begin
        wr_ptr_nxt = commit_ptr;
        drop_inc   = 1'b1;
      end else if (state == WS_IDLE) begin
        drop_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      in_ready     <= 1'b0;
      pkt_drop_cnt <= '0;
      pkt_out_cnt  <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      level      <= level_nxt;
      in_ready   <= level_nxt <= PTR_W'(DEPTH - HEADROOM);
      if (drop_inc)                      pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(1);
      if (pop && out_user[USER_EOP])     pkt_out_cnt  <= pkt_out_cnt + CNT_W'(1);
    end
  end

  md_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BEAT_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (wr_beat),
    .rd_en   (rd_issue),
    .rd_addr (fetch_ptr[AW-1:0]),
    .rd_data (rd_word)
  );

  assign rd_beat = beat_t'(rd_word);

  // Two-stage prefetch: RAM read register (s1) feeding the output register.
  assign avail    = commit_ptr != fetch_ptr;
  assign out_load = s1_valid && (!out_valid || out_ready);
  assign rd_issue = avail && (!s1_valid || out_load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_ptr <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_user  <= '0;
    end else begin
      if (rd_issue) fetch_ptr <= fetch_ptr + PTR_W'(1);
      if (rd_issue)      s1_valid <= 1'b1;
      else if (out_load) s1_valid <= 1'b0;
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= rd_beat.data;
        out_keep  <= rd_beat.keep;
        out_user  <= rd_beat.user;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_md_tx_pkt_buffer.sv
// Bench for md_tx_pkt_buffer: directed scenarios plus randomized traffic,
// all checked against a queue-based packet model.
module tb_md_tx_pkt_buffer;

  localparam int unsigned DEPTH    = 64;
  localparam int unsigned HEADROOM = 8;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned LW       = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [1:0]   user;
  } tb_beat_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [255:0]   in_data = '0;
  logic           in_data_wr = 1'b0;
  logic [31:0]    in_keep = '0;
  logic [1:0]     in_user = '0;
  logic           in_ready;
  logic [255:0]   out_data;
  logic [31:0]    out_keep;
  logic [1:0]     out_user;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [CNT_W-1:0] pkt_out_cnt;
  logic [CNT_W-1:0] pkt_drop_cnt;
  logic [LW-1:0]  level;

  always #5 clk = ~clk;

  md_tx_pkt_buffer #(
    .DEPTH    (DEPTH),
    .HEADROOM (HEADROOM),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_data_wr   (in_data_wr),
    .in_keep      (in_keep),
    .in_user      (in_user),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_user     (out_user),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pkt_out_cnt  (pkt_out_cnt),
    .pkt_drop_cnt (pkt_drop_cnt),
    .level        (level)
  );

  int total = 0;
  int bad   = 0;

  // Packet-level model: committed beats awaiting output, and the open packet.
  tb_beat_t exp_q[$];
  tb_beat_t part_q[$];
  bit       m_in_pkt;
  bit       m_dropping;
  int       m_drop;
  int       m_out;

  int cyc;
  int pop_first, pop_last, pop_n;
  int rdy_pct = 100;

  task automatic model_clear();
    exp_q.delete();
    part_q.delete();
    m_in_pkt   = 0;
    m_dropping = 0;
    m_drop     = 0;
    m_out      = 0;
  endtask

  // One clock: score any output handshake, apply the write to the model,
  // advance past the edge, then compare level/in_ready/counters.
  task automatic cycle();
    tb_beat_t b, got;
    bit       full, sop, eop;
    int       lvl;
    if (out_valid && out_ready) begin
      got = {out_data, out_keep, out_user};
      total++;
      if (pop_n == 0) pop_first = cyc;
      pop_last = cyc;
      pop_n++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_beat: unexpected beat user=%b keep=%h, required no beat", out_user, out_keep);
      end else begin
        b = exp_q.pop_front();
        if (got !== b) begin
          bad++;
          $display("FAIL out_beat: got user=%b keep=%h data=%h, required user=%b keep=%h data=%h",
                   got.user, got.keep, got.data, b.user, b.keep, b.data);
        end
        if (b.user[0]) m_out++;
      end
    end
    if (in_data_wr) begin
      sop  = in_user[1];
      eop  = in_user[0];
      b    = {in_data, in_keep, in_user};
      full = (exp_q.size() + part_q.size()) == DEPTH;
      if (sop || m_in_pkt) begin
        if (full) begin
          part_q.delete();
          m_drop++;
          m_in_pkt   = 0;
          m_dropping = !eop;
        end else begin
          if (m_in_pkt && sop) begin
            part_q.delete();
            m_drop++;
          end
          part_q.push_back(b);
          m_dropping = 0;
          if (eop) begin
            foreach (part_q[i]) exp_q.push_back(part_q[i]);
            part_q.delete();
            m_in_pkt = 0;
          end else begin
            m_in_pkt = 1;
          end
        end
      end else begin
        if (!m_dropping) m_drop++;
        m_dropping = !eop;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    lvl = exp_q.size() + part_q.size();
    total++;
    if (level !== LW'(lvl)) begin
      bad++;
      $display("FAIL level: got %0d, required %0d (cycle %0d)", level, lvl, cyc);
    end
    total++;
    if (in_ready !== (lvl <= int'(DEPTH - HEADROOM))) begin
      bad++;
      $display("FAIL in_ready: got %b, required %b at level %0d", in_ready, (lvl <= int'(DEPTH - HEADROOM)), lvl);
    end
    total++;
    if (pkt_drop_cnt !== CNT_W'(m_drop)) begin
      bad++;
      $display("FAIL pkt_drop_cnt: got %0d, required %0d", pkt_drop_cnt, m_drop);
    end
    total++;
    if (pkt_out_cnt !== CNT_W'(m_out)) begin
      bad++;
      $display("FAIL pkt_out_cnt: got %0d, required %0d", pkt_out_cnt, m_out);
    end
  endtask

  task automatic send(input bit sop, input bit eop);
    in_data_wr = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = $urandom();
    in_keep = $urandom();
    in_user = {sop, eop};
    cycle();
    in_data_wr = 1'b0;
  endtask

  task automatic idle();
    in_data_wr = 1'b0;
    cycle();
  endtask

  task automatic rsend(input bit sop, input bit eop);
    out_ready = ($urandom_range(0, 99) < rdy_pct);
    send(sop, eop);
  endtask

  task automatic ridle();
    out_ready = ($urandom_range(0, 99) < rdy_pct);
    idle();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
    end
    repeat (3) idle();
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    in_data_wr = 1'b0;
    in_user    = '0;
    out_ready  = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pop_n = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    total++;
    if (level !== '0) begin bad++; $display("FAIL rst_level: got %0d, required 0", level); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    total++;
    if (pkt_out_cnt !== '0 || pkt_drop_cnt !== '0) begin
      bad++;
      $display("FAIL rst_counters: got out=%0d drop=%0d, required 0/0", pkt_out_cnt, pkt_drop_cnt);
    end
    total++;
    if (out_user !== '0 || out_keep !== '0 || out_data !== '0) begin
      bad++;
      $display("FAIL rst_out_bus: got user=%b keep=%h, required zero", out_user, out_keep);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_pre_edge: got %b, required 0", in_ready); end
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_post_edge: got %b, required 1", in_ready); end
    model_clear();
  endtask

  task automatic test_single_pkt();
    apply_reset();
    out_ready = 1'b1;
    send(1, 0);
    send(0, 0);
    send(0, 0);
    send(0, 1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_edge_k: got out_valid=%b, required 0", out_valid); end
    idle();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_edge_k1: got out_valid=%b, required 0", out_valid); end
    idle();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_edge_k2: got out_valid=%b, required 1", out_valid); end
    drain();
    total++;
    if (pkt_out_cnt !== CNT_W'(1) || level !== '0) begin
      bad++;
      $display("FAIL single_pkt_end: got cnt=%0d level=%0d, required 1/0", pkt_out_cnt, level);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(1, 1);
    drain();
    total++;
    if (pop_n != 10 || (pop_last - pop_first) != 9) begin
      bad++;
      $display("FAIL b2b_bubbles: got %0d beats over %0d cycles, required 10 over 10", pop_n, pop_last - pop_first + 1);
    end
    total++;
    if (pkt_out_cnt !== CNT_W'(10) || pkt_drop_cnt !== '0) begin
      bad++;
      $display("FAIL b2b_counts: got out=%0d drop=%0d, required 10/0", pkt_out_cnt, pkt_drop_cnt);
    end
  endtask

  task automatic test_overflow();
    int n;
    apply_reset();
    out_ready = 1'b0;
    n = 0;
    for (int p = 0; p < 7; p++)
      for (int i = 0; i < 8; i++) begin
        send(i == 0, i == 7);
        n++;
      end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL ovf_ready_at_56: got %b, required 1", in_ready); end
    for (int i = 0; i < 10; i++) begin
      send(i == 0, i == 9);
      n++;
      if (n == 57) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready_at_57: got %b, required 0", in_ready); end
      end
    end
    total++;
    if (level !== LW'(56) || pkt_drop_cnt !== CNT_W'(1)) begin
      bad++;
      $display("FAIL ovf_rollback: got level=%0d drop=%0d, required 56/1", level, pkt_drop_cnt);
    end
    drain();
    total++;
    if (pkt_out_cnt !== CNT_W'(7)) begin bad++; $display("FAIL ovf_out: got %0d, required 7", pkt_out_cnt); end
  endtask

  task automatic test_missing_eop();
    apply_reset();
    out_ready = 1'b1;
    send(1, 0);
    send(0, 0);
    send(0, 0);
    for (int i = 0; i < 4; i++) send(i == 0, i == 3);
    drain();
    total++;
    if (pkt_drop_cnt !== CNT_W'(1) || pkt_out_cnt !== CNT_W'(1)) begin
      bad++;
      $display("FAIL missing_eop: got drop=%0d out=%0d, required 1/1", pkt_drop_cnt, pkt_out_cnt);
    end
  endtask

  task automatic test_headless();
    apply_reset();
    out_ready = 1'b1;
    send(0, 0);
    send(0, 0);
    send(0, 1);
    repeat (3) idle();
    total++;
    if (out_valid !== 1'b0 || pkt_drop_cnt !== CNT_W'(1)) begin
      bad++;
      $display("FAIL headless: got out_valid=%b drop=%0d, required 0/1", out_valid, pkt_drop_cnt);
    end
    send(1, 0);
    send(0, 1);
    drain();
    total++;
    if (pkt_out_cnt !== CNT_W'(1)) begin bad++; $display("FAIL headless_next: got %0d, required 1", pkt_out_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) send(i == 0, i == 3);
    for (int i = 0; i < 20 && !out_valid; i++) idle();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre: got out_valid=%b, required 1", out_valid); end
    rst_n = 1'b0;
    model_clear();
    #1;
    total++;
    if (out_valid !== 1'b0 || level !== '0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async: got valid=%b level=%0d in_ready=%b, required 0/0/0", out_valid, level, in_ready);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready: got %b, required 1", in_ready); end
    send(1, 0);
    send(0, 1);
    drain();
    total++;
    if (pkt_out_cnt !== CNT_W'(1)) begin bad++; $display("FAIL rmid_next: got %0d, required 1", pkt_out_cnt); end
  endtask

  task automatic test_random();
    int kind, len;
    apply_reset();
    for (int p = 0; p < 150; p++) begin
      kind    = $urandom_range(0, 99);
      rdy_pct = $urandom_range(10, 100);
      if (kind < 80) begin
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) rsend(i == 0, i == len - 1);
      end else if (kind < 87) begin
        len = $urandom_range(1, 5);
        for (int i = 0; i < len; i++) rsend(i == 0, 0);
      end else if (kind < 94) begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) rsend(0, i == len - 1);
      end else if (kind < 97) begin
        for (int i = 0; i < 70; i++) rsend(i == 0, i == 69);
      end else begin
        repeat ($urandom_range(5, 30)) ridle();
      end
      repeat ($urandom_range(0, 2)) ridle();
    end
    // Close any open packet so everything committed can drain.
    rsend(1, 1);
    drain();
    total++;
    if (pkt_out_cnt !== CNT_W'(m_out) || level !== '0) begin
      bad++;
      $display("FAIL random_end: got out=%0d level=%0d, required %0d/0", pkt_out_cnt, level, m_out);
    end
  endtask

  initial begin
    cyc   = 0;
    pop_n = 0;
    model_clear();
    test_reset();
    test_single_pkt();
    test_back_to_back();
    test_overflow();
    test_missing_eop();
    test_headless();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
